// File: rtl/fifo_uart_tx.sv
// Drains bytes from a registered-output FIFO and serialises each one as an
// 8N1/8N2 UART frame on tx. Frame = START, 8 data bits LSB first, stop bit(s).
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_data,
    output logic        fifo_rd_en,
    output logic        tx,
    output logic        busy,
    output logic        tx_done,
    output logic [15:0] frames_sent
);
    typedef enum logic [2:0] {IDLE, POP, LATCH, START, DATA, STOP} state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] BAUD_PRE  = 16'(CLKS_PER_BIT - 2);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

    state_t      state_q;
    logic [15:0] baud_q;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic        rd_en_q;
    logic        tx_q;
    logic        done_q;
    logic [15:0] frames_q;

    logic        baud_wrap;
    logic        stop_last;
    logic        can_pop;
    logic [15:0] frames_d;

    assign baud_wrap = (baud_q == BAUD_LAST);
    assign stop_last = (bit_q == STOP_LAST);
    assign can_pop   = en && !fifo_empty;
    assign frames_d  = frames_q + 16'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            rd_en_q  <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
            frames_q <= '0;
        end else begin
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    baud_q <= '0;
                    bit_q  <= '0;
                    if (can_pop) begin
                        state_q <= POP;
                        rd_en_q <= 1'b1;
                    end
                end
                POP: begin
                    state_q <= LATCH;
                end
                LATCH: begin
                    // FIFO data_out became valid on the edge that ended POP
                    shift_q <= fifo_data;
                    tx_q    <= 1'b0;
                    baud_q  <= '0;
                    state_q <= START;
                end
                START: begin
                    if (baud_wrap) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_wrap) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            bit_q   <= '0;
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                STOP: begin
                    // Registered pulse: set one cycle early so it lands on the final stop cycle
                    if (stop_last && baud_q == BAUD_PRE) begin
                        done_q   <= 1'b1;
                        frames_q <= frames_d;
                    end
                    if (baud_wrap) begin
                        baud_q <= '0;
                        if (stop_last) begin
                            bit_q <= '0;
                            if (can_pop) begin
                                state_q <= POP;
                                rd_en_q <= 1'b1;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign fifo_rd_en  = rd_en_q;
    assign tx          = tx_q;
    assign busy        = (state_q != IDLE);
    assign tx_done     = done_q;
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: two instances (1 and 2 stop bits) fed by
// small behavioural FIFO models with registered read data.
module tb_fifo_uart_tx;
    logic        clk = 1'b0;
    logic        reset;
    logic        en, en2;
    logic        fifo_empty, fifo2_empty;
    logic [7:0]  fifo_data, fifo2_data;
    logic        fifo_rd_en, fifo2_rd_en;
    logic        tx, tx2;
    logic        busy, busy2;
    logic        tx_done, tx_done2;
    logic [15:0] frames_sent, frames_sent2;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [16];
    logic [7:0] mem2 [16];
    int wr_cnt = 0, rd_cnt = 0;
    int wr2_cnt = 0, rd2_cnt = 0;
    logic underflow = 1'b0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u_dut (
        .clk(clk), .reset(reset), .en(en), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy),
        .tx_done(tx_done), .frames_sent(frames_sent)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .reset(reset), .en(en2), .fifo_empty(fifo2_empty),
        .fifo_data(fifo2_data), .fifo_rd_en(fifo2_rd_en), .tx(tx2), .busy(busy2),
        .tx_done(tx_done2), .frames_sent(frames_sent2)
    );

    assign fifo_empty  = (wr_cnt == rd_cnt);
    assign fifo2_empty = (wr2_cnt == rd2_cnt);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fifo_empty) underflow <= 1'b1;
            fifo_data <= mem[rd_cnt % 16];
            rd_cnt    <= rd_cnt + 1;
        end
        if (fifo2_rd_en) begin
            if (fifo2_empty) underflow <= 1'b1;
            fifo2_data <= mem2[rd2_cnt % 16];
            rd2_cnt    <= rd2_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_cnt % 16] = b;
        wr_cnt = wr_cnt + 1;
    endtask

    // Waits at most 'limit' extra cycles for a read pulse; limit 0 demands it now.
    task automatic wait_pop(input string tag, input bit sel, input int limit);
        int i = 0;
        while (!(sel ? fifo2_rd_en : fifo_rd_en) && i < limit) begin
            @(negedge clk);
            i++;
        end
        chk({tag, "_pop"}, sel ? fifo2_rd_en : fifo_rd_en, 1);
        @(negedge clk);
        chk({tag, "_latch_rd"}, sel ? fifo2_rd_en : fifo_rd_en, 0);
        chk({tag, "_latch_tx"}, sel ? tx2 : tx, 1);
        @(negedge clk);
    endtask

    // Called on the first START cycle; returns on the cycle after the last stop cycle.
    task automatic check_frame(input string tag, input logic [7:0] b, input int stop_bits,
                               input bit sel, input int drop_at);
        int   total;
        logic e_tx;
        total = (9 + stop_bits) * 4;
        for (int i = 0; i < total; i++) begin
            if (i == drop_at) en = 1'b0;
            if (i < 4)       e_tx = 1'b0;
            else if (i < 36) e_tx = b[(i - 4) / 4];
            else             e_tx = 1'b1;
            chk($sformatf("%s_tx[%0d]", tag, i), sel ? tx2 : tx, e_tx);
            chk($sformatf("%s_done[%0d]", tag, i), sel ? tx_done2 : tx_done, (i == total - 1));
            chk($sformatf("%s_busy[%0d]", tag, i), sel ? busy2 : busy, 1);
            chk($sformatf("%s_rd[%0d]", tag, i), sel ? fifo2_rd_en : fifo_rd_en, 0);
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        en2   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rd", fifo_rd_en, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_frames", frames_sent, 0);
        reset = 1'b0;

        // Empty FIFO with enable: must stay idle
        en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk($sformatf("idle_tx[%0d]", i), tx, 1);
            chk($sformatf("idle_rd[%0d]", i), fifo_rd_en, 0);
            chk($sformatf("idle_busy[%0d]", i), busy, 0);
            chk($sformatf("idle_frames[%0d]", i), frames_sent, 0);
        end

        // Single byte 0xA5
        push(8'hA5);
        @(negedge clk);
        wait_pop("a5", 1'b0, 0);
        check_frame("a5", 8'hA5, 1, 1'b0, -1);
        chk("a5_busy_after", busy, 0);
        chk("a5_frames", frames_sent, 1);
        chk("a5_pulses", rd_cnt, 1);

        // Back-to-back 0x00, 0xFF: second pop immediately after stop bit
        push(8'h00);
        push(8'hFF);
        @(negedge clk);
        wait_pop("b2b0", 1'b0, 0);
        check_frame("b2b0", 8'h00, 1, 1'b0, -1);
        wait_pop("b2b1", 1'b0, 0);
        check_frame("b2b1", 8'hFF, 1, 1'b0, -1);
        chk("b2b_busy_after", busy, 0);
        chk("b2b_frames", frames_sent, 3);
        chk("b2b_pulses", rd_cnt, 3);

        // en dropped during data bit 3 (cycles 16..19 of frame)
        push(8'h3C);
        push(8'h11);
        @(negedge clk);
        wait_pop("endrop", 1'b0, 0);
        check_frame("endrop", 8'h3C, 1, 1'b0, 17);
        chk("endrop_busy", busy, 0);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("endrop_nord[%0d]", i), fifo_rd_en, 0);
            @(negedge clk);
        end
        chk("endrop_frames", frames_sent, 4);
        chk("endrop_left", wr_cnt - rd_cnt, 1);

        // Two stop bits, 0x81
        mem2[wr2_cnt % 16] = 8'h81;
        wr2_cnt = wr2_cnt + 1;
        en2 = 1'b1;
        @(negedge clk);
        wait_pop("sb2", 1'b1, 0);
        check_frame("sb2", 8'h81, 2, 1'b1, -1);
        chk("sb2_busy_after", busy2, 0);
        chk("sb2_frames", frames_sent2, 1);
        chk("sb2_pulses", rd2_cnt, 1);
        en2 = 1'b0;

        // Async reset mid-DATA, between clock edges
        en = 1'b1;
        @(negedge clk);
        wait_pop("arst", 1'b0, 0);
        repeat (10) @(negedge clk);
        chk("arst_pre_tx", tx, 1'b0);
        #1 reset = 1'b1;
        #1;
        chk("arst_tx", tx, 1);
        chk("arst_busy", busy, 0);
        chk("arst_rd", fifo_rd_en, 0);
        @(negedge clk);
        push(8'h5A);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("arst_frames", frames_sent, 0);
        chk("arst_popped", rd_cnt, 5);
        @(negedge clk);
        wait_pop("post", 1'b0, 0);
        check_frame("post", 8'h5A, 1, 1'b0, -1);
        chk("post_frames", frames_sent, 1);
        chk("post_left", wr_cnt - rd_cnt, 0);
        chk("underflow", underflow, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Drain-side consumer for the 16-stage, 8-bit FIFO. It pops bytes through the FIFO read port (rd_en / is_empty / registered data_out) and serialises each byte as an 8N1 (or 8N2) UART frame on a single tx line. It sits between the FIFO top level and the board's UART TX pin, and is the read-end counterpart of the producer that writes the FIFO.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit; legal range 2..65535.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
en  input  1  transmit enable; sampled only when a new byte is to be fetched.
fifo_empty  input  1  FIFO is_empty flag.
fifo_data  input  8  FIFO data_out; registered in the FIFO, valid the cycle after rd_en.
fifo_rd_en  output  1  FIFO rd_en; one-cycle pulse per byte.
tx  output  1  serial line; idle high.
busy  output  1  high whenever the FSM is not in IDLE.
tx_done  output  1  one-cycle pulse in the last cycle of the final stop bit.
frames_sent  output  16  count of completed frames; wraps 0xFFFF -> 0x0000.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-high.
- Reset values: tx=1, fifo_rd_en=0, busy=0, tx_done=0, frames_sent=0, state=IDLE, bit counter=0, baud counter=0.
- Reset asserted mid-frame: tx returns to 1 immediately. The partially sent byte is dropped and is not re-popped.
- All outputs are registered or decoded from state only. There are no combinational paths from input to output.
- FSM states are IDLE, POP, LATCH, START, DATA, STOP.
- IDLE -> POP: when en=1 and fifo_empty=0.
- POP: lasts exactly 1 cycle with fifo_rd_en=1. The FIFO registers data_out on the edge that ends POP.
- LATCH: lasts 1 cycle. The shift register captures fifo_data on the edge that ends LATCH. Next state is START.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each held for CLKS_PER_BIT cycles. A 3-bit counter tracks bit index 0..7.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. tx_done=1 and frames_sent increments in the last STOP cycle.
- Exit from STOP: go to POP if en=1 and fifo_empty=0, otherwise go to IDLE.
- Latency: the first fifo_rd_en cycle follows the cycle in which IDLE sees en=1 and fifo_empty=0. tx falls 2 cycles after the fifo_rd_en cycle.
- Frame length is (9+STOP_BITS)*CLKS_PER_BIT cycles. Back-to-back frames have a gap of exactly 2 extra high cycles (POP + LATCH) beyond the stop bits.
- Baud counter: 16 bits, counts 0..CLKS_PER_BIT-1 and reloads at each bit boundary.
- Empty FIFO: fifo_rd_en is never asserted while fifo_empty=1, so underflow is never caused.
- en deasserted mid-frame: the current frame completes unchanged, then the FSM goes to IDLE with no further pops.
- en and fifo_empty are ignored in START, DATA and STOP.
- tx stays steady high in IDLE. busy=1 in POP through STOP.

Test Plan:
- Reset then idle: CLKS_PER_BIT=4, fifo_empty=1, en=1 for 100 cycles -> tx=1, fifo_rd_en=0, busy=0, frames_sent=0 throughout.
- Single byte 0xA5, CLKS_PER_BIT=4, STOP_BITS=1 -> fifo_rd_en is one 1-cycle pulse, and tx falls 2 cycles later.
  - tx sequence in 4-cycle bits: 0, 1,0,1,0,0,1,0,1, 1.
  - tx_done pulses once and frames_sent=1.
- Back-to-back bytes 0x00 then 0xFF queued in the FIFO -> frames are 40 cycles each, separated by exactly 2 extra high cycles.
  - fifo_rd_en pulses twice, and frames_sent=2 at the end.
- en dropped during bit 3 of 0x3C with 2 bytes queued -> 0x3C completes.
  - No further fifo_rd_en is asserted, the FSM reaches IDLE, and 1 byte remains in the FIFO.
- STOP_BITS=2, CLKS_PER_BIT=4, byte 0x81 -> stop-high period is 8 cycles and the frame is 44 cycles.
- Async reset asserted mid-DATA between clock edges -> tx=1 and busy=0 immediately, before the next edge.
  - After release, frames_sent=0 and the next queued byte transmits normally.
